// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streamer: FSM encoding and counter width helpers.
package fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int burst_cnt_w(input int burst);
      return $clog2(burst + 1);
   endfunction

   function automatic int timeout_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order output queue; the head entry drives the output directly from flops.
module stream_skid2 #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         space,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data
);

   logic [1:0]   cnt;
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic         take;

   assign valid = (cnt != 2'd0);
   assign data  = head;
   assign take  = valid & ready;
   // a full queue still accepts a word in the cycle its head is taken
   assign space = (cnt < 2'd2) || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         case ({push, take})
            2'b10: begin
               if (cnt == 2'd0) head <= push_data;
               else             tail <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               head <= tail;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pulls words from a FWFT FIFO and emits them as fixed-length bursts, draining
// leftover partial data as single-word bursts after an idle timeout.
//
//  state | meaning
//  IDLE  | no pops; counts idle cycles while only partial data is present
//  BURST | pops BURST words, last flag on the final one; waits if the FIFO runs dry
//  DRAIN | pops every available word as a single-word burst
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DW      = 32,
   parameter int BURST   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic          rd_clk,
   input  logic          rd_reset_n,
   input  logic          fifo_empty,
   input  logic          fifo_aempty,
   input  logic [DW-1:0] fifo_rd_data,
   output logic          fifo_rd_en,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
);

   localparam int BW = burst_cnt_w(BURST);
   localparam int TW = timeout_cnt_w(TIMEOUT);

   state_t        state;
   logic [BW-1:0] burst_cnt;
   logic [TW-1:0] to_cnt;
   logic          space;
   logic          pop_last;
   logic [DW:0]   buf_data;

   assign pop_last   = (state == ST_DRAIN) || (burst_cnt == BW'(1));
   assign fifo_rd_en = (state != ST_IDLE) && !fifo_empty && space;
   assign m_data     = buf_data[DW:1];
   assign m_last     = buf_data[0];

   always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         to_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_aempty) begin
                  state     <= ST_BURST;
                  burst_cnt <= BW'(BURST);
                  to_cnt    <= '0;
               end else if (!fifo_empty) begin
                  if (to_cnt == TW'(TIMEOUT - 1)) begin
                     state  <= ST_DRAIN;
                     to_cnt <= '0;
                  end else begin
                     to_cnt <= to_cnt + TW'(1);
                  end
               end else begin
                  to_cnt <= '0;
               end
            end
            ST_BURST: begin
               if (fifo_rd_en) begin
                  burst_cnt <= burst_cnt - BW'(1);
                  if (burst_cnt == BW'(1)) state <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!fifo_aempty) begin
                  state     <= ST_BURST;
                  burst_cnt <= BW'(BURST);
               end else if (fifo_empty) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   stream_skid2 #(.W(DW + 1)) u_skid (
      .clk       (rd_clk),
      .rst_n     (rd_reset_n),
      .push      (fifo_rd_en),
      .push_data ({fifo_rd_data, pop_last}),
      .space     (space),
      .valid     (m_valid),
      .ready     (m_ready),
      .data      (buf_data)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed bench for fifo_rd_stream against a queue-based behavioural model.
module tb_fifo_rd_stream;

   localparam int DW      = 32;
   localparam int BURST   = 4;
   localparam int TIMEOUT = 16;
   localparam int M_IDLE  = 0;
   localparam int M_BURST = 1;
   localparam int M_DRAIN = 2;

   logic          rd_clk = 1'b0;
   logic          rd_reset_n = 1'b1;
   logic          fifo_empty = 1'b1;
   logic          fifo_aempty = 1'b1;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_stream #(.DW(DW), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
      .rd_clk       (rd_clk),
      .rd_reset_n   (rd_reset_n),
      .fifo_empty   (fifo_empty),
      .fifo_aempty  (fifo_aempty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } ent_t;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] pushed_log[$];
   logic [DW-1:0] got_data[$];
   logic          got_last[$];
   ent_t          obuf[$];
   int            aempty_thr = BURST;

   int mode = M_IDLE;
   int brem = 0;
   int idle_n = 0;
   int cyc = 0;
   int pops_seen = 0;
   int first_pop_cyc = -1;
   int first_valid_cyc = -1;

   logic          e_pop, e_valid;
   logic          s_pop, s_valid, s_ready, s_last;
   logic [DW-1:0] s_data;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic drive_pins();
      fifo_empty   = (fifo_q.size() == 0);
      fifo_aempty  = (fifo_q.size() < aempty_thr);
      fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // compare process: check at negedge+1, advance the model at the following posedge
   initial begin
      forever begin
         @(negedge rd_clk);
         #1;
         e_valid = (obuf.size() > 0);
         e_pop   = (mode != M_IDLE) && (fifo_q.size() > 0) && ((obuf.size() < 2) || m_ready);
         s_pop   = fifo_rd_en;
         s_valid = m_valid;
         s_ready = m_ready;
         s_data  = m_data;
         s_last  = m_last;
         if (rd_reset_n) begin
            chk("fifo_rd_en", 64'(fifo_rd_en), 64'(e_pop));
            chk("m_valid", 64'(m_valid), 64'(e_valid));
            if (e_valid) begin
               chk("m_data", 64'(m_data), 64'(obuf[0].d));
               chk("m_last", 64'(m_last), 64'(obuf[0].l));
            end
         end
         @(posedge rd_clk);
         if (!rd_reset_n) begin
            obuf.delete();
            mode   = M_IDLE;
            brem   = 0;
            idle_n = 0;
         end else begin
            if (s_valid && s_ready) begin
               got_data.push_back(s_data);
               got_last.push_back(s_last);
            end
            if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_pop) begin
               pops_seen++;
               if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (e_valid && s_ready) void'(obuf.pop_front());
            if (e_pop) begin
               ent_t e;
               e.d = fifo_q[0];
               e.l = (mode == M_DRAIN) || (brem == 1);
               obuf.push_back(e);
            end
            if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            case (mode)
               M_IDLE: begin
                  if (!fifo_aempty) begin
                     mode = M_BURST; brem = BURST; idle_n = 0;
                  end else if (!fifo_empty) begin
                     idle_n++;
                     if (idle_n >= TIMEOUT) begin mode = M_DRAIN; idle_n = 0; end
                  end else begin
                     idle_n = 0;
                  end
               end
               M_BURST: begin
                  if (e_pop) begin
                     brem--;
                     if (brem == 0) mode = M_IDLE;
                  end
               end
               default: begin
                  if (!fifo_aempty) begin mode = M_BURST; brem = BURST; end
                  else if (fifo_empty) mode = M_IDLE;
               end
            endcase
         end
         cyc++;
      end
   end

   task automatic step(input int n_push, input logic rdy);
      logic [DW-1:0] w;
      @(negedge rd_clk);
      for (int i = 0; i < n_push; i++) begin
         w = $urandom;
         fifo_q.push_back(w);
         pushed_log.push_back(w);
      end
      m_ready = rdy;
      drive_pins();
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(0, rdy);
   endtask

   task automatic clear_logs();
      pushed_log.delete();
      got_data.delete();
      got_last.delete();
      pops_seen       = 0;
      first_pop_cyc   = -1;
      first_valid_cyc = -1;
   endtask

   task automatic cmp_stream(input string name);
      chk({name, "_count"}, 64'(got_data.size()), 64'(pushed_log.size()));
      for (int i = 0; i < got_data.size() && i < pushed_log.size(); i++)
         chk({name, "_word"}, 64'(got_data[i]), 64'(pushed_log[i]));
   endtask

   int t0;
   logic [7:0] lpat;

   initial begin
      #1 rd_reset_n = 1'b0;
      #2;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      @(negedge rd_clk);
      rd_reset_n = 1'b1;
      drive_pins();

      // two full bursts from 8 words
      clear_logs();
      step(8, 1'b1);
      t0 = cyc;
      run(14, 1'b1);
      chk("a_first_valid_lat", 64'(first_valid_cyc - t0), 64'd2);
      cmp_stream("a");
      lpat = '0;
      for (int i = 0; i < 8 && i < got_last.size(); i++) lpat[i] = got_last[i];
      chk("a_last_pattern", 64'(lpat), 64'h88);

      // partial data drained after timeout
      clear_logs();
      step(2, 1'b1);
      t0 = cyc;
      run(24, 1'b1);
      chk("b_first_pop_delay", 64'(first_pop_cyc - t0), 64'd16);
      cmp_stream("b");
      lpat = '0;
      for (int i = 0; i < 2 && i < got_last.size(); i++) lpat[i] = got_last[i];
      chk("b_last_pattern", 64'(lpat), 64'h3);
      chk("b_back_to_idle", 64'(dut.state), 64'd0);

      // backpressure: exactly two pops fill the buffer
      clear_logs();
      step(8, 1'b0);
      run(11, 1'b0);
      chk("c_pops_stalled", 64'(pops_seen), 64'd2);
      run(20, 1'b1);
      cmp_stream("c");

      // ready toggling every cycle
      clear_logs();
      step(8, 1'b1);
      for (int i = 0; i < 40; i++) step(0, logic'(i[0]));
      cmp_stream("d");

      // FIFO runs dry mid-burst, burst resumes on refill
      clear_logs();
      aempty_thr = 2;
      step(2, 1'b1);
      run(8, 1'b1);
      chk("e_wait_in_burst", 64'(dut.state), 64'd1);
      step(2, 1'b1);
      run(8, 1'b1);
      cmp_stream("e");
      lpat = '0;
      for (int i = 0; i < 4 && i < got_last.size(); i++) lpat[i] = got_last[i];
      chk("e_last_pattern", 64'(lpat), 64'h8);
      aempty_thr = BURST;

      // reset pulse mid-burst with two words buffered
      clear_logs();
      step(8, 1'b0);
      run(6, 1'b0);
      @(negedge rd_clk);
      #2 rd_reset_n = 1'b0;
      #1;
      chk("f_rst_m_valid", 64'(m_valid), 64'd0);
      chk("f_rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("f_rst_state", 64'(dut.state), 64'd0);
      chk("f_rst_m_data", 64'(m_data), 64'd0);
      fifo_q.delete();
      drive_pins();
      @(negedge rd_clk);
      rd_reset_n = 1'b1;
      drive_pins();
      run(3, 1'b1);
      chk("f_pops_total", 64'(pops_seen), 64'd2);

      // randomized traffic in blocks of varying fill rate and backpressure
      clear_logs();
      for (int blk = 0; blk < 12; blk++) begin
         int rate;
         int rdy_pct;
         rate    = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 5 : (blk % 4 == 2) ? 30 : 70;
         rdy_pct = $urandom_range(20, 100);
         for (int i = 0; i < 250; i++) begin
            int np;
            np = (fifo_q.size() < 16 && $urandom_range(0, 99) < rate) ? 1 : 0;
            step(np, logic'($urandom_range(0, 99) < rdy_pct));
         end
      end
      run(60, 1'b1);
      cmp_stream("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
